// File: rtl/hsv_pkg.sv
// Shared pixel constants, mask encodings and the bounding-box record used by
// the HSV threshold / blob statistics stage.
package hsv_pkg;

  localparam int PIX_W = 8;

  localparam logic [PIX_W-1:0] MASK_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] MASK_OFF = 8'h00;

  localparam int BB_X_W   = 11;
  localparam int BB_Y_W   = 11;
  localparam int BB_CNT_W = 22;

  typedef struct packed {
    logic [BB_X_W-1:0]   x_min;
    logic [BB_X_W-1:0]   x_max;
    logic [BB_Y_W-1:0]   y_min;
    logic [BB_Y_W-1:0]   y_max;
    logic [BB_CNT_W-1:0] count;
  } bbox_t;

  // Empty-frame accumulator: mins at all ones so the first pixel always wins.
  localparam bbox_t BBOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, count: '0};

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } blob_state_t;

endpackage

// File: rtl/hsv_range_cmp.sv
// Purpose: per-pixel HSV window test with wrap-aware hue range.
// Latency: combinational.
// Backpressure: none; evaluated every cycle.
module hsv_range_cmp
  import hsv_pkg::*;
(
  input  logic [PIX_W-1:0] h,
  input  logic [PIX_W-1:0] s,
  input  logic [PIX_W-1:0] v,
  input  logic             de,
  input  logic [PIX_W-1:0] h_lo,
  input  logic [PIX_W-1:0] h_hi,
  input  logic [PIX_W-1:0] s_min,
  input  logic [PIX_W-1:0] v_min,
  output logic             pass
);

  logic hue_ok;

  // h_lo > h_hi means the window spans the 255 -> 0 hue seam.
  always_comb begin
    hue_ok = 1'b0;
    if (h_lo <= h_hi) hue_ok = (h >= h_lo) && (h <= h_hi);
    else              hue_ok = (h >= h_lo) || (h <= h_hi);
  end

  assign pass = de & hue_ok & (s >= s_min) & (v >= v_min);

endmodule

// File: rtl/hsv_blob_stats.sv
// Purpose: HSV threshold to binary mask plus per-frame bbox/count; HSV_BLOB_CENTROID_EN adds x/y sums.
// Latency: mask and syncs 1 cycle; stats latched at vsync rise, stat_valid the cycle after.
// Backpressure: none; ce low freezes every register.
module hsv_blob_stats
  import hsv_pkg::*;
#(
  parameter int X_W   = BB_X_W,
  parameter int Y_W   = BB_Y_W,
  parameter int CNT_W = BB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [PIX_W-1:0] H,
  input  logic [PIX_W-1:0] S,
  input  logic [PIX_W-1:0] V,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_de,
  input  logic [PIX_W-1:0] h_lo,
  input  logic [PIX_W-1:0] h_hi,
  input  logic [PIX_W-1:0] s_min,
  input  logic [PIX_W-1:0] v_min,
  output logic [PIX_W-1:0] mask_pix,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_de,
  output logic             stat_valid,
  output logic [X_W-1:0]   bb_x_min,
  output logic [X_W-1:0]   bb_x_max,
  output logic [Y_W-1:0]   bb_y_min,
  output logic [Y_W-1:0]   bb_y_max,
  output logic [CNT_W-1:0] pix_count
`ifdef HSV_BLOB_CENTROID_EN
  ,
  output logic [X_W+CNT_W-1:0] sum_x,
  output logic [Y_W+CNT_W-1:0] sum_y
`endif
);

  logic              pass;
  logic              prev_vsync;
  logic              prev_de;
  logic              vs_rise;
  logic              de_fall;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic [BB_X_W-1:0] x_pos;
  logic [BB_Y_W-1:0] y_pos;
  bbox_t             run;
  bbox_t             run_nx;
  blob_state_t       state;

  hsv_range_cmp u_range_cmp (
    .h     (H),
    .s     (S),
    .v     (V),
    .de    (in_de),
    .h_lo  (h_lo),
    .h_hi  (h_hi),
    .s_min (s_min),
    .v_min (v_min),
    .pass  (pass)
  );

  assign vs_rise = in_vsync & ~prev_vsync;
  assign de_fall = ~in_de & prev_de;
  assign x_pos   = BB_X_W'(x_cnt);
  assign y_pos   = BB_Y_W'(y_cnt);

  // Accumulator value including this cycle's pixel, so an edge-cycle pixel is folded in.
  always_comb begin
    run_nx = run;
    if (pass) begin
      if (run.count != '1)     run_nx.count = run.count + 1'b1;
      if (x_pos < run.x_min)   run_nx.x_min = x_pos;
      if (x_pos > run.x_max)   run_nx.x_max = x_pos;
      if (y_pos < run.y_min)   run_nx.y_min = y_pos;
      if (y_pos > run.y_max)   run_nx.y_max = y_pos;
    end
  end

`ifdef HSV_BLOB_CENTROID_EN
  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  logic [SX_W-1:0] run_sum_x;
  logic [SY_W-1:0] run_sum_y;
  logic [SX_W-1:0] sum_x_nx;
  logic [SY_W-1:0] sum_y_nx;

  assign sum_x_nx = pass ? run_sum_x + SX_W'(x_cnt) : run_sum_x;
  assign sum_y_nx = pass ? run_sum_y + SY_W'(y_cnt) : run_sum_y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev_vsync <= 1'b0;
      prev_de    <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      run        <= BBOX_INIT;
      mask_pix   <= MASK_OFF;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_de     <= 1'b0;
      stat_valid <= 1'b0;
      bb_x_min   <= '0;
      bb_x_max   <= '0;
      bb_y_min   <= '0;
      bb_y_max   <= '0;
      pix_count  <= '0;
`ifdef HSV_BLOB_CENTROID_EN
      run_sum_x  <= '0;
      run_sum_y  <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
`endif
    end else if (ce) begin
      prev_vsync <= in_vsync;
      prev_de    <= in_de;
      mask_pix   <= pass ? MASK_ON : MASK_OFF;
      out_hsync  <= in_hsync;
      out_vsync  <= in_vsync;
      out_de     <= in_de;
      stat_valid <= 1'b0;

      if (in_de) begin
        if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      end else if (prev_de) begin
        x_cnt <= '0;
      end

      if (vs_rise)                           y_cnt <= '0;
      else if (de_fall && (y_cnt != '1))     y_cnt <= y_cnt + 1'b1;

      if (vs_rise) begin
        run   <= BBOX_INIT;
        state <= ST_ACCUM;
`ifdef HSV_BLOB_CENTROID_EN
        run_sum_x <= '0;
        run_sum_y <= '0;
`endif
        // The first edge after reset only opens a frame; there is nothing to report.
        if (state == ST_ACCUM) begin
          stat_valid <= 1'b1;
          if (run_nx.count != '0) begin
            bb_x_min  <= X_W'(run_nx.x_min);
            bb_x_max  <= X_W'(run_nx.x_max);
            bb_y_min  <= Y_W'(run_nx.y_min);
            bb_y_max  <= Y_W'(run_nx.y_max);
            pix_count <= CNT_W'(run_nx.count);
`ifdef HSV_BLOB_CENTROID_EN
            sum_x     <= sum_x_nx;
            sum_y     <= sum_y_nx;
`endif
          end else begin
            bb_x_min  <= '0;
            bb_x_max  <= '0;
            bb_y_min  <= '0;
            bb_y_max  <= '0;
            pix_count <= '0;
`ifdef HSV_BLOB_CENTROID_EN
            sum_x     <= '0;
            sum_y     <= '0;
`endif
          end
        end
      end else begin
        run <= run_nx;
`ifdef HSV_BLOB_CENTROID_EN
        run_sum_x <= sum_x_nx;
        run_sum_y <= sum_y_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hsv_blob_stats.sv
// Randomised frames against a frame-level reference model; a monitor pops
// per-cycle expectations and per-frame stats records and compares them.
module tb_hsv_blob_stats;

  localparam int X_W   = 11;
  localparam int Y_W   = 11;
  localparam int CNT_W = 22;

  logic             clk;
  logic             rst;
  logic             ce;
  logic [7:0]       H, S, V;
  logic             in_hsync, in_vsync, in_de;
  logic [7:0]       h_lo, h_hi, s_min, v_min;
  logic [7:0]       mask_pix;
  logic             out_hsync, out_vsync, out_de;
  logic             stat_valid;
  logic [X_W-1:0]   bb_x_min, bb_x_max;
  logic [Y_W-1:0]   bb_y_min, bb_y_max;
  logic [CNT_W-1:0] pix_count;
`ifdef HSV_BLOB_CENTROID_EN
  logic [X_W+CNT_W-1:0] sum_x;
  logic [Y_W+CNT_W-1:0] sum_y;
`endif

  hsv_blob_stats dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .H          (H),
    .S          (S),
    .V          (V),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_de      (in_de),
    .h_lo       (h_lo),
    .h_hi       (h_hi),
    .s_min      (s_min),
    .v_min      (v_min),
    .mask_pix   (mask_pix),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .out_de     (out_de),
    .stat_valid (stat_valid),
    .bb_x_min   (bb_x_min),
    .bb_x_max   (bb_x_max),
    .bb_y_min   (bb_y_min),
    .bb_y_max   (bb_y_max),
    .pix_count  (pix_count)
`ifdef HSV_BLOB_CENTROID_EN
    ,
    .sum_x      (sum_x),
    .sum_y      (sum_y)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int tgt;
    int mask;
    bit hs, vs, de, sv, fresh;
    int xmin, xmax, ymin, ymax, cnt;
  } exp_t;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt;
    longint sx, sy;
  } stat_t;

  exp_t  exp_q[$];
  stat_t stat_q[$];
  exp_t  m_last;
  bit    m_accum;
  bit    m_prev_vs;
  int    pass_x[$];
  int    pass_y[$];
  int    t_lo, t_hi, t_s, t_v;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Hue window as a modular distance from h_lo; covers both plain and wrapped windows.
  function automatic bit ref_pass(input int h, input int s, input int v, input bit de,
                                  input int lo, input int hi, input int smin, input int vmin);
    int span, off;
    span = (hi - lo + 256) % 256;
    off  = (h - lo + 256) % 256;
    return de && (off <= span) && (s >= smin) && (v >= vmin);
  endfunction

  task automatic drive(input int h, input int s, input int v, input bit hs, input bit vs,
                       input bit de, input bit c, input bit r, input int px, input int py);
    exp_t e;
    @(posedge clk);
    #1;
    H = 8'(h); S = 8'(s); V = 8'(v);
    in_hsync = hs; in_vsync = vs; in_de = de;
    h_lo = 8'(t_lo); h_hi = 8'(t_hi); s_min = 8'(t_s); v_min = 8'(t_v);
    ce = c; rst = r;
    e = m_last;
    e.fresh = 1'b0;
    if (r) begin
      e = '{default: 0};
      m_accum = 1'b0;
      m_prev_vs = 1'b0;
      pass_x.delete();
      pass_y.delete();
    end else if (c) begin
      bit p;
      p = ref_pass(h, s, v, de, t_lo, t_hi, t_s, t_v);
      e.mask = p ? 255 : 0;
      e.hs = hs; e.vs = vs; e.de = de; e.sv = 1'b0;
      if (p) begin
        pass_x.push_back(px);
        pass_y.push_back(py);
      end
      if (vs && !m_prev_vs) begin
        if (m_accum) begin
          stat_t st;
          st = '{default: 0};
          foreach (pass_x[i]) begin
            if (i == 0 || pass_x[i] < st.xmin) st.xmin = pass_x[i];
            if (i == 0 || pass_x[i] > st.xmax) st.xmax = pass_x[i];
            if (i == 0 || pass_y[i] < st.ymin) st.ymin = pass_y[i];
            if (i == 0 || pass_y[i] > st.ymax) st.ymax = pass_y[i];
            st.sx += pass_x[i];
            st.sy += pass_y[i];
          end
          st.cnt = pass_x.size();
          e.xmin = st.xmin; e.xmax = st.xmax; e.ymin = st.ymin; e.ymax = st.ymax; e.cnt = st.cnt;
          e.sv = 1'b1;
          e.fresh = 1'b1;
          stat_q.push_back(st);
        end
        m_accum = 1'b1;
        pass_x.delete();
        pass_y.delete();
      end
      m_prev_vs = vs;
    end
    e.tgt = cyc + 1;
    m_last = e;
    exp_q.push_back(e);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic stall_cycle();
    drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          0, 0, 0, 0);
  endtask

  task automatic vsync_gap();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    blank(2);
  endtask

  // kind 0: random pixels, 1: blob at cols 3..6 / lines 2..4, 2: every pixel below v_min
  task automatic lines(input int w, input int l_n, input int kind, input int y_off,
                       input int stall_line, input bit fold, input int rst_line, input bit rnd_stall);
    for (int l = 0; l < l_n; l++) begin
      drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      blank(2);
      for (int c = 0; c < w; c++) begin
        int h, s, v;
        bit last;
        if (l == rst_line && c == w / 2) begin
          drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
          drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
          return;
        end
        if (l == stall_line && c == 5) for (int k = 0; k < 5; k++) stall_cycle();
        if (rnd_stall && $urandom_range(0, 9) == 0) stall_cycle();
        h = $urandom_range(0, 255);
        s = $urandom_range(0, 255);
        v = $urandom_range(0, 255);
        if (kind == 1) begin
          h = (c >= 3 && c <= 6 && l >= 2 && l <= 4) ? 110 : 0;
          s = 200;
          v = 200;
        end else if (kind == 2) begin
          v = $urandom_range(0, 254);
        end
        last = fold && (l == l_n - 1) && (c == w - 1);
        if (last) begin
          h = t_lo; s = 255; v = 255;
        end
        drive(h, s, v, 0, last, 1, 1, 0, c, l + y_off);
      end
      if (!(fold && l == l_n - 1)) blank(2);
    end
  endtask

  task automatic rand_thr();
    t_lo = $urandom_range(0, 255);
    t_hi = $urandom_range(0, 255);
    t_s  = $urandom_range(0, 128);
    t_v  = $urandom_range(0, 128);
  endtask

  task automatic check_stats(input string tag, input int x0, input int x1, input int y0,
                             input int y1, input int n);
    #1;
    check({tag, " bb_x_min"}, bb_x_min, x0);
    check({tag, " bb_x_max"}, bb_x_max, x1);
    check({tag, " bb_y_min"}, bb_y_min, y0);
    check({tag, " bb_y_max"}, bb_y_max, y1);
    check({tag, " pix_count"}, pix_count, n);
  endtask

  // Monitor: one expectation per driven cycle, plus a stats record per fresh pulse.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("mask_pix", mask_pix, e.mask);
        check("out_hsync", out_hsync, e.hs);
        check("out_vsync", out_vsync, e.vs);
        check("out_de", out_de, e.de);
        check("stat_valid", stat_valid, e.sv);
        check("bb_x_min", bb_x_min, e.xmin);
        check("bb_x_max", bb_x_max, e.xmax);
        check("bb_y_min", bb_y_min, e.ymin);
        check("bb_y_max", bb_y_max, e.ymax);
        check("pix_count", pix_count, e.cnt);
        if (stat_valid === 1'b1 && e.fresh && stat_q.size() > 0) begin
          stat_t st;
          st = stat_q.pop_front();
          check("frame pix_count", pix_count, st.cnt);
`ifdef HSV_BLOB_CENTROID_EN
          check("frame sum_x", sum_x, st.sx);
          check("frame sum_y", sum_y, st.sy);
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1;
    H = '0; S = '0; V = '0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
    h_lo = '0; h_hi = '0; s_min = '0; v_min = '0;
    t_lo = 0; t_hi = 255; t_s = 0; t_v = 0;
    m_last = '{default: 0};
    m_accum = 1'b0;
    m_prev_vs = 1'b0;

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    blank(2);

    // plain and wrapped hue windows
    t_lo = 10; t_hi = 40;
    drive(25, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(41, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(25, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    t_lo = 240; t_hi = 15;
    drive(250, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(5, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(100, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    blank(2);

    // blob frame then empty frame
    t_lo = 100; t_hi = 120; t_s = 0; t_v = 0;
    vsync_gap();
    lines(16, 8, 1, 0, -1, 0, -1, 0);
    vsync_gap();
    check_stats("blob", 3, 6, 2, 4, 12);
    t_v = 255;
    lines(16, 8, 2, 0, -1, 0, -1, 0);
    vsync_gap();
    check_stats("empty", 0, 0, 0, 0, 0);

    // ce held low mid-line
    rand_thr();
    lines(16, 8, 0, 0, 3, 0, -1, 0);
    vsync_gap();

    // pass pixel coinciding with the vsync edge, then the frame after it
    rand_thr();
    lines(16, 6, 0, 0, -1, 1, -1, 0);
    vsync_gap();
    lines(16, 6, 0, 1, -1, 0, -1, 0);
    vsync_gap();

    // reset mid-frame: first edge after reset is silent, second reports
    rand_thr();
    lines(16, 8, 0, 0, -1, 0, 3, 0);
    blank(3);
    lines(8, 1, 0, 0, -1, 0, -1, 0);
    vsync_gap();
    lines(16, 8, 0, 0, -1, 0, -1, 0);
    vsync_gap();

    for (int f = 0; f < 6; f++) begin
      rand_thr();
      lines($urandom_range(4, 20), $urandom_range(1, 10), 0, 0, -1, 0, -1, 1);
      vsync_gap();
    end

    blank(3);
    repeat (2) @(posedge clk);
    #3;
    check("expectations drained", exp_q.size(), 0);
    check("stats records drained", stat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
